timer_device: RTL and testbench

//   Memory-mapped countdown timer. It answers the word load/store accesses

---
 rtl/timer_device.sv | 145 ++++++++++++++
 tb/tb_timer_device.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// The registers are CTRL (EN, MODE, IM), PRESET and a read-only COUNT.
// Reads are combinational. irq is a level in one-shot mode and a one-cycle
// pulse per period in auto-reload mode.
// COUNT_WIDTH must be between 1 and 32. Reads zero-extend to 32 bits.
module timer_device #(
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrPreset = 2'd1;
   localparam logic [1:0] AddrCount  = 2'd2;

   localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

   state_e                 state_q, state_d;
   logic [3:0]             ctrl_q, ctrl_d;
   logic [COUNT_WIDTH-1:0] preset_q, preset_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   pend_q, pend_d;

   logic ctrl_we;
   logic preset_we;
   logic en_eff;
   logic mode_auto;
   logic en_clr;
   logic pend_set;

   // Store decode. A same-edge CTRL store overrides EN as seen by LOAD and CNT.
   always_comb begin
      ctrl_we   = we && (addr == AddrCtrl);
      preset_we = we && (addr == AddrPreset);
      en_eff    = ctrl_we ? din[0] : ctrl_q[0];
      // MODE values 2 and 3 behave as one-shot.
      mode_auto = (ctrl_q[2:1] == 2'b01);
   end

   // Next state, COUNT update, and the EN-clear and pend-set events.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      en_clr   = 1'b0;
      pend_set = 1'b0;
      case (state_q)
         StIdle: begin
            if (ctrl_q[0]) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (!en_eff) begin
               state_d = StIdle;
            end else begin
               count_d = preset_q;
               state_d = StCnt;
            end
         end
         StCnt: begin
            if (!en_eff) begin
               state_d = StIdle;
            end else if (count_q == '0) begin
               state_d  = StInt;
               pend_set = !mode_auto;
            end else begin
               count_d = count_q - CountOne;
            end
         end
         StInt: begin
            if (mode_auto) begin
               state_d = StLoad;
            end else begin
               en_clr  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Register next values. A CPU store beats the hardware EN clear, and the pend clear beats the pend set.
   always_comb begin
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      pend_d   = pend_q;
      if (en_clr) begin
         ctrl_d[0] = 1'b0;
      end
      if (ctrl_we) begin
         ctrl_d = din[3:0];
      end
      if (preset_we) begin
         preset_d = din[COUNT_WIDTH-1:0];
      end
      if (pend_set) begin
         pend_d = 1'b1;
      end
      if (ctrl_we || preset_we) begin
         pend_d = 1'b0;
      end
   end

   // State and register update, with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   // Combinational read mux. Narrow registers are zero-extended.
   always_comb begin
      dout = '0;
      case (addr)
         AddrCtrl:   dout[3:0]             = ctrl_q;
         AddrPreset: dout[COUNT_WIDTH-1:0] = preset_q;
         AddrCount:  dout[COUNT_WIDTH-1:0] = count_q;
         default:    dout                  = '0;
      endcase
   end

   // Held level from pend, or a pulse for the duration of INT in auto-reload mode.
   always_comb begin
      irq = ctrl_q[3] & (pend_q | ((state_q == StInt) & mode_auto));
   end

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device. Expected COUNT, irq and CTRL values come
// from closed-form timing rules counted in edges after the enabling store.
module tb_timer_device;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int checks = 0;
   int errors = 0;

   timer_device #(.COUNT_WIDTH(32)) dut (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (dout),
      .irq  (irq)
   );

   always #5 clk = ~clk;

   // Wait for the next rising edge, then move 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Store a word. It lands on the next rising edge.
   task automatic store(input logic [1:0] a, input logic [31:0] d);
      we   = 1'b1;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
      we  = 1'b0;
      din = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = dout;
   endtask

   task automatic do_reset();
      we    = 1'b0;
      addr  = 2'd0;
      din   = '0;
      reset = 1'b1;
      #3;
      reset = 1'b0;
      tick();
   endtask

   // Reference model. The enabling store lands at edge 0, and the values are those seen after edge k.
   // COUNT starts at 0 from reset.
   function automatic logic [31:0] model_count(int p, bit auto_mode, int k);
      int t;
      int ph;
      t = k - 1;
      if (t < 1) return 32'd0;
      if (auto_mode) begin
         ph = (t - 1) % (p + 3);
         return (ph <= p) ? 32'(p - ph) : 32'd0;
      end
      return ((t - 1) <= p) ? 32'(p - (t - 1)) : 32'd0;
   endfunction

   function automatic logic model_irq(int p, bit auto_mode, bit im, int k);
      int t;
      t = k - 1;
      if (!im) return 1'b0;
      if (auto_mode) return (t >= 1) && (((t - 1) % (p + 3)) == p + 1);
      return k >= p + 3;
   endfunction

   function automatic logic [31:0] model_ctrl(logic [31:0] c, int p, bit auto_mode, int k);
      if (!auto_mode && k >= p + 4) return c & 32'hE;
      return c;
   endfunction

   task automatic test_reset();
      logic [31:0] v;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         checks++;
         if (v !== 32'd0) begin
            errors++;
            $display("FAIL reset_reg a=%0d: got %h expected 0", a, v);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_regs();
      logic [31:0] v;
      do_reset();
      store(2'd0, 32'hFFFF_FFF6);
      rd(2'd0, v);
      checks++;
      if (v !== 32'h6) begin
         errors++;
         $display("FAIL ctrl_mask: got %h expected 6", v);
      end
      store(2'd1, 32'hDEAD_BEEF);
      rd(2'd1, v);
      checks++;
      if (v !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL preset_rw: got %h expected deadbeef", v);
      end
      rd(2'd3, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL addr3_read: got %h expected 0", v);
      end
      store(2'd0, 32'd0);
   endtask

   task automatic test_reset_midcount();
      logic [31:0] v;
      do_reset();
      store(2'd1, 32'd8);
      store(2'd0, 32'h9);
      repeat (5) tick();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd5) begin
         errors++;
         $display("FAIL midcount_pre: got %0d expected 5", v);
      end
      reset = 1'b1;
      #1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         checks++;
         if (v !== 32'd0) begin
            errors++;
            $display("FAIL midcount_reset a=%0d: got %h expected 0", a, v);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL midcount_irq: got %b expected 0", irq);
      end
      reset = 1'b0;
      tick();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL midcount_post: got %0d expected 0", v);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      do_reset();
      store(2'd1, 32'd3);
      store(2'd0, 32'h9);
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k >= 2 && k <= 5) begin
            rd(2'd2, v);
            checks++;
            if (v !== 32'(5 - k)) begin
               errors++;
               $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, v, 5 - k);
            end
         end
         checks++;
         if (irq !== (k >= 6)) begin
            errors++;
            $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, irq, k >= 6);
         end
         if (k >= 7) begin
            rd(2'd0, v);
            checks++;
            if (v !== 32'h8) begin
               errors++;
               $display("FAIL oneshot_ctrl k=%0d: got %h expected 8", k, v);
            end
         end
      end
      store(2'd0, 32'h8);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_clear: got %b expected 0", irq);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] v;
      int pulses;
      do_reset();
      store(2'd1, 32'd2);
      store(2'd0, 32'hB);
      pulses = 0;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (irq === 1'b1) pulses++;
         checks++;
         if (irq !== (k >= 5 && (k - 5) % 5 == 0)) begin
            errors++;
            $display("FAIL auto_irq k=%0d: got %b", k, irq);
         end
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL auto_pulses: got %0d expected 4", pulses);
      end
      rd(2'd0, v);
      checks++;
      if (v !== 32'hB) begin
         errors++;
         $display("FAIL auto_ctrl: got %h expected b", v);
      end
   endtask

   task automatic test_preset_zero();
      logic [31:0] v;
      do_reset();
      store(2'd1, 32'd0);
      store(2'd0, 32'h3);
      for (int k = 1; k <= 12; k++) begin
         tick();
         rd(2'd2, v);
         checks++;
         if (v !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL p0_masked k=%0d: got count=%0d irq=%b expected 0/0", k, v, irq);
         end
      end
      rd(2'd0, v);
      checks++;
      if (v !== 32'h3) begin
         errors++;
         $display("FAIL p0_ctrl: got %h expected 3", v);
      end
      do_reset();
      store(2'd1, 32'd0);
      store(2'd0, 32'hB);
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (irq !== (k % 3 == 0)) begin
            errors++;
            $display("FAIL p0_period k=%0d: got %b expected %b", k, irq, k % 3 == 0);
         end
      end
   endtask

   task automatic test_disable_hold();
      logic [31:0] v;
      do_reset();
      store(2'd1, 32'd10);
      store(2'd0, 32'h1);
      repeat (6) tick();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd6) begin
         errors++;
         $display("FAIL hold_pre: got %0d expected 6", v);
      end
      store(2'd0, 32'h0);
      repeat (3) tick();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd6 || irq !== 1'b0) begin
         errors++;
         $display("FAIL hold_count: got %0d irq=%b expected 6 irq=0", v, irq);
      end
      store(2'd2, 32'h55);
      store(2'd3, 32'hFFFF_FFFF);
      rd(2'd2, v);
      checks++;
      if (v !== 32'd6) begin
         errors++;
         $display("FAIL count_readonly: got %h expected 6", v);
      end
      rd(2'd3, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL addr3_ignored: got %h expected 0", v);
      end
   endtask

   task automatic test_pend_clear_race();
      logic [31:0] v;
      do_reset();
      store(2'd1, 32'd1);
      store(2'd0, 32'h9);
      repeat (3) tick();
      store(2'd1, 32'd4);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL race_irq: got %b expected 0", irq);
      end
      rd(2'd1, v);
      checks++;
      if (v !== 32'd4) begin
         errors++;
         $display("FAIL race_preset: got %0d expected 4", v);
      end
      tick();
      rd(2'd0, v);
      checks++;
      if (v !== 32'h8 || irq !== 1'b0) begin
         errors++;
         $display("FAIL race_after: got ctrl=%h irq=%b expected 8/0", v, irq);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      do_reset();
      store(2'd1, 32'd0);
      store(2'd0, 32'h9);
      repeat (3) tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got %b expected 1", irq);
      end
      store(2'd0, 32'h9);
      rd(2'd0, v);
      checks++;
      if (v !== 32'h9 || irq !== 1'b0) begin
         errors++;
         $display("FAIL b2b_cpu_wins: got ctrl=%h irq=%b expected 9/0", v, irq);
      end
      for (int k = 5; k <= 7; k++) begin
         tick();
         checks++;
         if (irq !== (k == 7)) begin
            errors++;
            $display("FAIL b2b_rerun k=%0d: got %b expected %b", k, irq, k == 7);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [31:0] c;
      int p;
      int mode;
      bit im;
      bit am;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         p    = int'($urandom_range(0, 6));
         mode = int'($urandom_range(0, 3));
         im   = 1'($urandom_range(0, 1));
         am   = (mode == 1);
         c    = {28'd0, im, 2'(mode), 1'b1};
         store(2'd1, 32'(p));
         store(2'd0, c);
         for (int k = 1; k <= 3 * (p + 3) + 3; k++) begin
            tick();
            rd(2'd2, v);
            checks++;
            if (v !== model_count(p, am, k)) begin
               errors++;
               $display("FAIL rand_count p=%0d m=%0d k=%0d: got %0d expected %0d",
                        p, mode, k, v, model_count(p, am, k));
            end
            checks++;
            if (irq !== model_irq(p, am, im, k)) begin
               errors++;
               $display("FAIL rand_irq p=%0d m=%0d im=%0d k=%0d: got %b expected %b",
                        p, mode, im, k, irq, model_irq(p, am, im, k));
            end
            rd(2'd0, v);
            checks++;
            if (v !== model_ctrl(c, p, am, k)) begin
               errors++;
               $display("FAIL rand_ctrl p=%0d m=%0d k=%0d: got %h expected %h",
                        p, mode, k, v, model_ctrl(c, p, am, k));
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 2'd0;
      din   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_regs();
      test_reset_midcount();
      test_oneshot();
      test_autoreload();
      test_preset_zero();
      test_disable_hold();
      test_pend_clear_race();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
